// File: rtl/inner_loop_acc_pkg.sv
// Shared constants, derived widths and state encoding
// for the inner-loop accumulator and its sequencer.
package inner_loop_acc_pkg;

    localparam int SIZE          = 3072;
    localparam int RADIX         = 108;
    localparam int WORDS_PER_CLK = 6;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_w(input int size, input int radix);
        return size + radix + 2;
    endfunction

    function automatic int calc_nw(input int size, input int radix);
        return ceil_div(calc_w(size, radix), radix);
    endfunction

    function automatic int calc_nc(input int size, input int radix,
                                   input int wpc);
        return ceil_div(calc_nw(size, radix), wpc);
    endfunction

    localparam int W   = calc_w(SIZE, RADIX);
    localparam int NW  = calc_nw(SIZE, RADIX);
    localparam int NC  = calc_nc(SIZE, RADIX, WORDS_PER_CLK);
    localparam int IW  = NW * RADIX;
    localparam int CW  = WORDS_PER_CLK * RADIX;
    localparam int PW  = NC * CW;
    localparam int CIW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        SHIFT
    } acc_state_t;

endpackage

// File: rtl/acc_chunk_adder.sv
// Three-operand adder over one chunk of radix words,
// carry ripples word to word and out of the chunk.
import inner_loop_acc_pkg::*;

module acc_chunk_adder (
    input  logic [CW-1:0] acc_chunk,
    input  logic [CW-1:0] r0_chunk,
    input  logic [CW-1:0] r1_chunk,
    input  logic [1:0]    carry_in,
    output logic [CW-1:0] sum_chunk,
    output logic [1:0]    carry_out
);

    logic [RADIX+1:0] s;
    logic [1:0]       c;

    // Word-serial add; each word sum fits in radix+2 bits
    always_comb begin
        sum_chunk = '0;
        s         = '0;
        c         = carry_in;
        for (int i = 0; i < WORDS_PER_CLK; i++) begin
            s = (RADIX+2)'(acc_chunk[i*RADIX +: RADIX])
              + (RADIX+2)'(r0_chunk[i*RADIX +: RADIX])
              + (RADIX+2)'(r1_chunk[i*RADIX +: RADIX])
              + (RADIX+2)'(c);
            sum_chunk[i*RADIX +: RADIX] = s[RADIX-1:0];
            c = s[RADIX+1:RADIX];
        end
        carry_out = c;
    end

endmodule

// File: rtl/inner_loop_acc.sv
// Accumulates the multiplier's redundant pair, emits the
// low radix digit and shifts the accumulator right by radix.
import inner_loop_acc_pkg::*;

module inner_loop_acc (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     r0,
    input  logic [W-1:0]     r1,
    output logic             in_ready,
    output logic [RADIX-1:0] digit_out,
    output logic             done,
    output logic [W-1:0]     acc_out,
    output logic             ovf,
    output logic             drop_err
);

    acc_state_t     state;
    logic [IW-1:0]  acc;
    logic [IW-1:0]  r0_q;
    logic [IW-1:0]  r1_q;
    logic [PW-1:0]  t;
    logic [CIW-1:0] chunk;
    logic [1:0]     carry;

    logic [PW-1:0]  acc_pad;
    logic [PW-1:0]  r0_pad;
    logic [PW-1:0]  r1_pad;
    logic [IW-1:0]  t_iw;
    logic [31:0]    base;
    logic [CW-1:0]  sum_chunk;
    logic [1:0]     carry_nxt;

    assign acc_pad   = PW'(acc);
    assign r0_pad    = PW'(r0_q);
    assign r1_pad    = PW'(r1_q);
    assign t_iw      = t[IW-1:0];
    assign base      = 32'(chunk) * 32'(CW);
    assign in_ready  = (state == IDLE);
    assign acc_out   = acc[W-1:0];

    acc_chunk_adder u_add (
        .acc_chunk (acc_pad[base +: CW]),
        .r0_chunk  (r0_pad[base +: CW]),
        .r1_chunk  (r1_pad[base +: CW]),
        .carry_in  (carry),
        .sum_chunk (sum_chunk),
        .carry_out (carry_nxt)
    );

    // Control FSM plus accumulator datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            t         <= '0;
            digit_out <= '0;
            chunk     <= '0;
            carry     <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        acc      <= '0;
                        ovf      <= 1'b0;
                        drop_err <= 1'b0;
                    end
                    if (in_valid) begin
                        r0_q  <= IW'(r0);
                        r1_q  <= IW'(r1);
                        chunk <= '0;
                        carry <= '0;
                        state <= SUM;
                    end
                end
                SUM: begin
                    if (in_valid) drop_err <= 1'b1;
                    t[base +: CW] <= sum_chunk;
                    carry         <= carry_nxt;
                    if (chunk == CIW'(NC-1)) state <= SHIFT;
                    else chunk <= chunk + 1'b1;
                end
                SHIFT: begin
                    if (in_valid) drop_err <= 1'b1;
                    digit_out <= t_iw[RADIX-1:0];
                    acc       <= t_iw >> RADIX;
                    ovf       <= ovf | (|t_iw[IW-1:W]);
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inner_loop_acc.sv
// Bench for inner_loop_acc: directed vector table, corner
// sequences and random invocations against an integer model.
import inner_loop_acc_pkg::*;

module tb_inner_loop_acc;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     r0 = '0;
    logic [W-1:0]     r1 = '0;
    logic             in_ready;
    logic [RADIX-1:0] digit_out;
    logic             done;
    logic [W-1:0]     acc_out;
    logic             ovf;
    logic             drop_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [IW-1:0] acc_m;
    logic          ovf_m;

    typedef struct {
        logic         clr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_dig;
        logic [W-1:0] e_acc;
        logic         e_ovf;
    } vec_t;

    vec_t tab [6];

    inner_loop_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .r0        (r0),
        .r1        (r1),
        .in_ready  (in_ready),
        .digit_out (digit_out),
        .done      (done),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (low 64 bits)",
                     name, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] ones(input int n);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] pow2(input int n);
        logic [W-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < (W + 31) / 32; k++)
            v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Integer model: acc' = (acc + r0 + r1) >> radix
    task automatic model_op(input logic clr, input logic [W-1:0] a,
                            input logic [W-1:0] b,
                            output logic [RADIX-1:0] dig);
        logic [IW+1:0] t;
        if (clr) begin
            acc_m = '0;
            ovf_m = 1'b0;
        end
        t = (IW+2)'(acc_m) + (IW+2)'(a) + (IW+2)'(b);
        dig = t[RADIX-1:0];
        if ((t >> W) != '0) ovf_m = 1'b1;
        acc_m = IW'(t >> RADIX);
    endtask

    task automatic run_op(input logic clr, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        @(negedge clk);
        clear    = clr;
        in_valid = 1'b1;
        r0       = a;
        r1       = b;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("in_ready_busy", W'(in_ready), W'(0));
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int               lat;
        int               pulses;
        logic [RADIX-1:0] dig;
        logic             clr;
        logic [W-1:0]     a;
        logic [W-1:0]     b;

        tab[0] = '{1'b0, W'(1), W'(2), W'(3), W'(0), 1'b0};
        tab[1] = '{1'b1, ones(RADIX), W'(1), W'(0), W'(1), 1'b0};
        tab[2] = '{1'b1, ones(6*RADIX), W'(1), W'(0),
                   pow2(5*RADIX), 1'b0};
        tab[3] = '{1'b1, W'(5), W'(0), W'(5), W'(0), 1'b0};
        tab[4] = '{1'b0, pow2(RADIX), W'(7), W'(7), W'(1), 1'b0};
        tab[5] = '{1'b1, ones(W), ones(W), ones(RADIX) - W'(1),
                   ones(W + 1 - RADIX), 1'b1};
        acc_m = '0;
        ovf_m = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_done", W'(done), W'(0));
        chk("rst_acc", acc_out, W'(0));
        chk("rst_digit", W'(digit_out), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        chk("rst_drop", W'(drop_err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tab[i].clr, tab[i].a, tab[i].b, lat);
            model_op(tab[i].clr, tab[i].a, tab[i].b, dig);
            chk($sformatf("vec%0d_latency", i), W'(lat), W'(6));
            chk($sformatf("vec%0d_digit", i), W'(digit_out),
                tab[i].e_dig);
            chk($sformatf("vec%0d_acc", i), acc_out, tab[i].e_acc);
            chk($sformatf("vec%0d_ovf", i), W'(ovf), W'(tab[i].e_ovf));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_fall", i), W'(done), W'(0));
            chk($sformatf("vec%0d_digit_hold", i), W'(digit_out),
                tab[i].e_dig);
        end

        // Extra in_valid while busy is dropped and flagged
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        r0       = W'(1);
        r1       = W'(2);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        r0       = ones(W);
        r1       = ones(W);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model_op(1'b1, W'(1), W'(2), dig);
        chk("drop_latency", W'(lat), W'(6));
        chk("drop_digit", W'(digit_out), W'(3));
        chk("drop_acc", acc_out, W'(0));
        chk("drop_ovf", W'(ovf), W'(0));
        chk("drop_flag", W'(drop_err), W'(1));
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("drop_cleared", W'(drop_err), W'(0));

        // Reset in the middle of an accumulation
        run_op(1'b1, pow2(3*RADIX), W'(0), lat);
        chk("pre_rst_acc", acc_out, pow2(2*RADIX));
        @(negedge clk);
        in_valid = 1'b1;
        r0       = W'(9);
        r1       = W'(9);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_acc", acc_out, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("midrst_no_done", W'(pulses), W'(0));
        acc_m = '0;
        ovf_m = 1'b0;

        // Random invocations, issued back to back
        for (int i = 0; i < 24; i++) begin
            clr = (i == 0) || ($urandom_range(0, 3) == 0);
            a = rand_w();
            b = rand_w();
            if ($urandom_range(0, 2) != 0)
                a = a & ones($urandom_range(1, W - 8));
            if ($urandom_range(0, 2) != 0)
                b = b & ones($urandom_range(1, W - 8));
            run_op(clr, a, b, lat);
            model_op(clr, a, b, dig);
            chk($sformatf("rnd%0d_latency", i), W'(lat), W'(6));
            chk($sformatf("rnd%0d_digit", i), W'(digit_out), W'(dig));
            chk($sformatf("rnd%0d_acc", i), acc_out, acc_m[W-1:0]);
            chk($sformatf("rnd%0d_ovf", i), W'(ovf), W'(ovf_m));
            chk($sformatf("rnd%0d_drop", i), W'(drop_err), W'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
